// File: rtl/s27_scan_array_if.sv
// Port bundle for s27_scan_array: mode/scan controls, per-channel s27 pins,
// scan output and the compaction results (signature and cycle count).
interface s27_scan_array_if #(
    parameter int NCH   = 4,
    parameter int SIG_W = 16,
    parameter int CNT_W = 16
);
    logic             en;
    logic             se;
    logic             si;
    logic             sig_clr;
    logic [NCH-1:0]   g0;
    logic [NCH-1:0]   g1;
    logic [NCH-1:0]   g2;
    logic [NCH-1:0]   g3;
    logic [NCH-1:0]   g17;
    logic             so;
    logic [SIG_W-1:0] sig;
    logic [CNT_W-1:0] cyc;

    modport master (
        output en, se, si, sig_clr, g0, g1, g2, g3,
        input  g17, so, sig, cyc
    );

    modport slave (
        input  en, se, si, sig_clr, g0, g1, g2, g3,
        output g17, so, sig, cyc
    );
endinterface

// File: rtl/s27_scan_array.sv
// NCH parallel s27 cores sharing one scan chain over all state flops, with a
// MISR compacting G17 and a saturating functional-cycle counter.
module s27_scan_array #(
    parameter int               NCH   = 4,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h002D,
    parameter int               CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    s27_scan_array_if.slave   bus
);

    logic [NCH-1:0]   s5_reg, s6_reg, s7_reg;
    logic [NCH-1:0]   g10, g11, g13, g17;
    logic [NCH-1:0]   scan_in;
    logic [SIG_W-1:0] sig_reg, sig_next;
    logic [CNT_W-1:0] cyc_reg, cyc_next;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic g14, g12, g8, g15, g16, g9;

            assign g14     = ~bus.g0[gi];
            assign g12     = ~(bus.g1[gi] | s7_reg[gi]);
            assign g8      = g14 & s6_reg[gi];
            assign g15     = g12 | g8;
            assign g16     = bus.g3[gi] | g8;
            assign g9      = ~(g16 & g15);
            assign g11[gi] = ~(s5_reg[gi] | g9);
            assign g10[gi] = ~(g14 | g11[gi]);
            assign g13[gi] = ~(bus.g2[gi] | g12);
            assign g17[gi] = ~g11[gi];

            // Chain runs SI -> ch0.S5 -> ch0.S6 -> ch0.S7 -> ch1.S5 -> ...
            if (gi == 0) begin : g_head
                assign scan_in[gi] = bus.si;
            end else begin : g_link
                assign scan_in[gi] = s7_reg[gi-1];
            end
        end
    endgenerate

    assign bus.g17 = g17;
    assign bus.so  = s7_reg[NCH-1];
    assign bus.sig = sig_reg;
    assign bus.cyc = cyc_reg;

    always_comb begin
        sig_next = {sig_reg[SIG_W-2:0], 1'b0}
                 ^ (sig_reg[SIG_W-1] ? POLY : '0)
                 ^ SIG_W'(g17);
        cyc_next = (&cyc_reg) ? cyc_reg : cyc_reg + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s5_reg <= '0;
            s6_reg <= '0;
            s7_reg <= '0;
        end else if (bus.en) begin
            if (bus.se) begin
                s5_reg <= scan_in;
                s6_reg <= s5_reg;
                s7_reg <= s6_reg;
            end else begin
                s5_reg <= g10;
                s6_reg <= g11;
                s7_reg <= g13;
            end
        end
    end

    // Clear wins over compaction; scan cycles leave signature and count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_reg <= '0;
            cyc_reg <= '0;
        end else if (bus.en) begin
            if (bus.sig_clr) begin
                sig_reg <= '0;
                cyc_reg <= '0;
            end else if (!bus.se) begin
                sig_reg <= sig_next;
                cyc_reg <= cyc_next;
            end
        end
    end

endmodule

// File: doc/s27_scan_array.md
# s27_scan_array

Parametrised multi-channel successor to the single s27 benchmark core, used as a fault-injection demo DUT. The block holds NCH independent s27 channels and adds a scan chain over all state flops, so state can be loaded and observed directly. It also compacts the G17 outputs into a MISR signature and counts functional cycles, so the injection harness can detect a fault without cycle-by-cycle comparison.

## Interface
- NCH, 4: number of s27 channels; 1..SIG_W
- SIG_W, 16: MISR width
- POLY, 16'h002D: MISR feedback polynomial, x^16+x^5+x^3+x^2+1, without the x^SIG_W term
- CNT_W, 16: functional-cycle counter width
- CK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- EN  in  1  global clock enable; 0 holds all state
- SE  in  1  scan enable; 1 = shift mode, 0 = functional mode
- SI  in  1  scan serial input
- SIG_CLR  in  1  synchronous clear of SIG and CYC
- G0, G1, G2, G3  in  NCH each  per-channel primary inputs; bit i belongs to channel i
- G17  out  NCH  per-channel primary output
- SO  out  1  scan serial output
- SIG  out  SIG_W  MISR signature
- CYC  out  CNT_W  functional-cycle count, saturating

## Operation
- Per channel i, the state is the register triple S5, S6, S7. The combinational logic is:
  - G14 = ~G0
  - G12 = ~(G1 | S7)
  - G8 = G14 & S6
  - G15 = G12 | G8
  - G16 = G3 | G8
  - G9 = ~(G16 & G15)
  - G11 = ~(S5 | G9)
  - G10 = ~(G14 | G11)
  - G13 = ~(G2 | G12)
  - G17 = ~G11
- G17 is combinational (Mealy) from current state and inputs. It is valid in both modes.
- Functional update (EN=1, SE=0): S5<=G10, S6<=G11, S7<=G13, all channels in parallel.
- Scan shift (EN=1, SE=1): the chain order is SI -> ch0.S5 -> ch0.S6 -> ch0.S7 -> ch1.S5 -> ... -> ch(NCH-1).S7. Each bit moves one position per cycle.
- SO = ch(NCH-1).S7, driven directly from the register. Chain length is 3*NCH.
- MISR update, only on functional cycles: SIG <= ({SIG[SIG_W-2:0],1'b0} ^ (SIG[SIG_W-1] ? POLY : 0)) ^ zero-extended G17.
- CYC increments on each functional cycle and saturates at all-ones.
- SIG and CYC hold during scan cycles and when EN=0.
- SIG_CLR=1 on an edge sets SIG=0 and CYC=0. It overrides the MISR/counter update in that cycle. Channel state and scan behaviour are unaffected.
- EN=0: no register changes, including SIG_CLR.
- Priority: RST > EN > SIG_CLR > mode update.

## Timing
- Reset (RST=0, asynchronous): all S5/S6/S7=0, SIG=0, CYC=0, SO=0. G17 then follows inputs combinationally.
- Release of RST is synchronous to the next CK rising edge. The first update occurs on the first rising edge with RST=1.
- Latency:
  - G17 has zero-cycle latency from inputs.
  - State, SIG and CYC update one edge after the qualifying cycle.
  - A bit entering SI appears on SO after 3*NCH shift edges.
- An SE change takes effect on the same edge. There is no mode-switch bubble.
- A mid-shift or mid-run reset clears everything immediately. The partial scan load is lost, and the harness must reload.
- CYC at all-ones stays all-ones on further functional cycles. Only SIG_CLR or RST clears it.
- SIG_W < NCH is illegal. NCH = SIG_W is legal, and G17 then covers the whole SIG.

## Test plan
1. Reset, NCH=4, all inputs 0, EN=1, SE=0, 3 edges:
   - G17 stays 4'hF and all state stays 0.
   - SIG goes 0x000F, 0x0011, 0x002D.
   - CYC goes 1, 2, 3.
2. From reset, G0=4'b0001 for 1 edge:
   - ch0.S5 becomes 1; other channels stay 0.
   - Scan out with SE=1 for 12 edges: SO reads 0 for the first 11 edges, then 1 on the 12th edge (the ch0.S5 bit reaches SO last).
3. Scan load of pattern 12'hA5C, MSB first, followed by 12 further shift edges with SI=0:
   - SO reproduces A5C MSB first.
   - SIG and CYC are unchanged throughout.
4. RST pulsed low during shift edge 6 of a load:
   - SO=0, SIG=0 and CYC=0 immediately, without a clock edge.
   - The post-reset functional run matches scenario 1.
5. EN=0 with SIG_CLR=1, then EN=1 with SIG_CLR=1 during a functional cycle with nonzero state:
   - First case: nothing changes.
   - Second case: SIG=0 and CYC=0 after the edge, while channel state still advances.
6. CNT_W=4, 20 functional edges: CYC reaches 15 at edge 15 and holds 15 through edge 20.
